// File: rtl/multicycle_slice_alu.sv
// multicycle_slice_alu: WIDTH-bit ALU that computes SLICE_W bits per clock, LSB slice first.
// The inter-slice carry is held in a register. Decodes MIPS funct codes AND/OR/ADD/SUB/SLT.
// Any other funct code executes as ADD.
// Optional feature macro: ALU_OVF_EN adds a registered signed-overflow output port 'ovf'.
// Reset is synchronous and active-low.
// Issue protocol: an operation is accepted on an edge where start=1 and busy=0.
// done pulses, with busy low, NSLICE cycles after the accept edge.
// start is also accepted in the done cycle, so back-to-back issue repeats every NSLICE+1 cycles.
module multicycle_slice_alu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = $clog2(NSLICE) + 1;
    localparam int unsigned SW1    = SLICE_W + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_SLT = 6'd42;

    // Reject slice widths that do not tile the operand exactly.
    generate
        if ((WIDTH % SLICE_W) != 0) begin : g_bad_slice
            $error("multicycle_slice_alu: WIDTH must be a multiple of SLICE_W");
        end
    endgenerate

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [5:0]       ctl_q, ctl_d;
    logic             inv_q, inv_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
`ifdef ALU_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [SLICE_W-1:0] a_sl_c;
    logic [SLICE_W-1:0] b_sl_c;
    logic [SLICE_W-1:0] slice_c;
    logic [SLICE_W:0]   sum_c;
    logic               arith_c;
    logic               ovf_c;
    logic               set_c;
    logic               last_c;
    logic [WIDTH-1:0]   acc_next_c;
    logic [WIDTH-1:0]   a_shift_c;
    logic [WIDTH-1:0]   b_shift_c;
    logic [WIDTH-1:0]   final_c;
    logic               sub_in_c;

    // Slice datapath: one SLICE_W-bit op on the low slice of the operand shift registers.
    always_comb begin
        a_sl_c  = a_q[SLICE_W-1:0];
        b_sl_c  = b_q[SLICE_W-1:0] ^ {SLICE_W{inv_q}};
        sum_c   = {1'b0, a_sl_c} + {1'b0, b_sl_c} + SW1'(carry_q);
        arith_c = (ctl_q != F_AND) && (ctl_q != F_OR);
        slice_c = sum_c[SLICE_W-1:0];
        if (ctl_q == F_AND) begin
            slice_c = a_sl_c & b_sl_c;
        end else if (ctl_q == F_OR) begin
            slice_c = a_sl_c | b_sl_c;
        end
        // Only meaningful on the last slice, where the slice MSBs are the word MSBs.
        ovf_c      = (a_sl_c[SLICE_W-1] == b_sl_c[SLICE_W-1]) &&
                     (sum_c[SLICE_W-1] != a_sl_c[SLICE_W-1]);
        set_c      = sum_c[SLICE_W-1] ^ ovf_c;
        last_c     = (cnt_q == CNT_W'(NSLICE - 1));
        acc_next_c = WIDTH'({slice_c, acc_q} >> SLICE_W);
        a_shift_c  = WIDTH'({{SLICE_W{1'b0}}, a_q} >> SLICE_W);
        b_shift_c  = WIDTH'({{SLICE_W{1'b0}}, b_q} >> SLICE_W);
        final_c    = (ctl_q == F_SLT) ? WIDTH'(set_c) : acc_next_c;
        sub_in_c   = (ctl == F_SUB) || (ctl == F_SLT);
    end

    // Next-state and register-input logic for the IDLE/RUN sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        ctl_d    = ctl_q;
        inv_d    = inv_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
`ifdef ALU_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    a_d     = a;
                    b_d     = b;
                    ctl_d   = ctl;
                    inv_d   = sub_in_c;
                    carry_d = sub_in_c;
                end
            end
            S_RUN: begin
                a_d     = a_shift_c;
                b_d     = b_shift_c;
                acc_d   = acc_next_c;
                carry_d = sum_c[SLICE_W];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_c) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    result_d = final_c;
                    cout_d   = arith_c & sum_c[SLICE_W];
                    zero_d   = (final_c == '0);
`ifdef ALU_OVF_EN
                    ovf_d    = arith_c && (ctl_q != F_SLT) && ovf_c;
`endif
                end
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            ctl_q    <= '0;
            inv_q    <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
`ifdef ALU_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            ctl_q    <= ctl_d;
            inv_q    <= inv_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
`ifdef ALU_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;
`ifdef ALU_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule
